// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with same-cycle hits, single-word fills
// on a miss, and saturating hit/miss counters.
module icache_direct #(
  parameter int          SETS    = 16,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [0:0]  state_dbg
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = 30 - IDX;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Memory handshake: in FILL, iREN/iaddr stay asserted and stable; the word on iload
  // is taken in the first cycle with iREN=1 and iwait=0, which also ends the fill.
  logic [0:0]      state_q, state_d;
  logic [31:0]     maddr_q, maddr_d;
  logic [31:0]     hit_count_q, hit_count_d;
  logic [31:0]     miss_count_q, miss_count_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [IDX-1:0] req_idx, fill_idx;
  logic [TW-1:0]  req_tag, fill_tag;
  logic           lookup_hit, fill_we;
  logic           unused_ok;

  assign req_idx    = imemaddr[IDX+1:2];
  assign req_tag    = imemaddr[31:IDX+2];
  assign fill_idx   = maddr_q[IDX+1:2];
  assign fill_tag   = maddr_q[31:IDX+2];
  assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_ok  = &{1'b0, PC_INIT, imemaddr[1:0], maddr_q[1:0]};

  always_comb begin
    state_d  = state_q;
    maddr_d  = maddr_q;
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    fill_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = data_q[req_idx];
        end else if (imemREN) begin
          maddr_d = {imemaddr[31:2], 2'b00};
          state_d = FILL;
        end
      end
      default: begin
        iREN  = 1'b1;
        iaddr = maddr_q;
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
          // Bypass only if the datapath is still asking for the word being filled.
          if (imemREN && (imemaddr[31:2] == maddr_q[31:2])) begin
            ihit     = 1'b1;
            imemload = iload;
          end
        end
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_we) valid_d[fill_idx] = 1'b1;
    hit_count_d  = (ihit && hit_count_q != CNT_MAX) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (fill_we && miss_count_q != CNT_MAX) ? miss_count_q + 32'd1 : miss_count_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      maddr_q      <= 32'h0;
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      maddr_q      <= maddr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data need no reset: the valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus random fetch streams, checked every
// cycle against a word-address-level cache model.
module tb_icache_direct;
  localparam int          SETS    = 16;
  localparam logic [31:0] PC_INIT = 32'h0;
  localparam int          W       = 130;
  localparam logic [31:0] MAX     = 32'hFFFF_FFFF;

  logic        clk, rst;
  logic        imemREN, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;
  logic [0:0]  state_dbg;

  icache_direct #(.SETS(SETS), .PC_INIT(PC_INIT)) dut (
    .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // model: frames hold the full word address they cache
  bit          m_valid [SETS];
  logic [31:0] m_waddr [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_filling;
  logic [31:0] m_faddr, m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_filling = 1'b0;
    m_faddr   = 32'h0;
    m_hits    = 32'h0;
    m_misses  = 32'h0;
  endtask

  task automatic model_step();
    logic        e_hit, e_ren;
    logic [31:0] e_load, e_addr, wa;
    int          s, fs;
    e_hit = 1'b0; e_ren = 1'b0; e_load = 32'h0; e_addr = 32'h0;
    wa = imemaddr >> 2;
    s  = int'(wa % SETS);
    if (!m_filling) begin
      if (imemREN && m_valid[s] && m_waddr[s] == wa) begin
        e_hit = 1'b1; e_load = m_data[s];
      end
    end else begin
      e_ren = 1'b1; e_addr = m_faddr;
      if (!iwait && imemREN && wa == (m_faddr >> 2)) begin
        e_hit = 1'b1; e_load = mem_word(m_faddr);
      end
    end
    exp_q.push_back({e_hit, e_ren, e_load, e_addr, m_hits, m_misses});
    if (!m_filling) begin
      if (imemREN && !e_hit) begin
        m_filling = 1'b1;
        m_faddr   = wa << 2;
      end
    end else if (!iwait) begin
      fs = int'((m_faddr >> 2) % SETS);
      m_valid[fs] = 1'b1;
      m_waddr[fs] = m_faddr >> 2;
      m_data[fs]  = mem_word(m_faddr);
      m_filling   = 1'b0;
      if (m_misses != MAX) m_misses = m_misses + 1;
    end
    if (e_hit && m_hits != MAX) m_hits = m_hits + 1;
  endtask

  // driver: inputs change at negedge, model expectation pushed 1 time unit later
  task automatic cycle(input logic ren, input logic [31:0] addr, input logic wt);
    @(negedge clk);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = iREN ? mem_word(iaddr) : $urandom();
    #1;
    model_step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every driven cycle is compared against the model
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ihit, iREN, imemload, iaddr, hit_count, miss_count};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_compare t=%0t: got ihit=%b iREN=%b load=%h iaddr=%h hits=%h misses=%h expected ihit=%b iREN=%b load=%h iaddr=%h hits=%h misses=%h",
                   $time, a[129], a[128], a[127:96], a[95:64], a[63:32], a[31:0],
                   e[129], e[128], e[127:96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  logic [31:0] cur;

  initial begin
    rst = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_ihit", {31'h0, ihit}, 32'h0);
    check("reset_iREN", {31'h0, iREN}, 32'h0);
    check("reset_iaddr", iaddr, 32'h0);
    check("reset_imemload", imemload, 32'h0);
    check("reset_hit_count", hit_count, 32'h0);
    check("reset_miss_count", miss_count, 32'h0);
    rst = 1'b0;

    // first fetch of 0x0: three iREN cycles, bypass hit on the third
    cycle(1'b1, 32'h0, 1'b1);
    check("cold_miss_ihit", {31'h0, ihit}, 32'h0);
    cycle(1'b1, 32'h0, 1'b1);
    check("fill1_iREN", {31'h0, iREN}, 32'h1);
    cycle(1'b1, 32'h0, 1'b1);
    check("fill2_iaddr", iaddr, 32'h0);
    cycle(1'b1, 32'h0, 1'b0);
    check("fill3_ihit", {31'h0, ihit}, 32'h1);
    check("fill3_load", imemload, 32'h2001_0005);
    cycle(1'b1, 32'h0, 1'b1);
    check("refetch_ihit", {31'h0, ihit}, 32'h1);
    check("refetch_iREN", {31'h0, iREN}, 32'h0);
    check("refetch_load", imemload, 32'h2001_0005);
    check("refetch_miss_count", miss_count, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    check("refetch_hit_count", hit_count, 32'h2);

    // conflict on set 1: 0x04 / 0x44 / 0x04
    cycle(1'b1, 32'h4, 1'b1);
    cycle(1'b1, 32'h4, 1'b0);
    cycle(1'b1, 32'h44, 1'b1);
    check("conflict_miss_44", {31'h0, ihit}, 32'h0);
    cycle(1'b1, 32'h44, 1'b0);
    check("conflict_load_44", imemload, mem_word(32'h44));
    cycle(1'b1, 32'h4, 1'b1);
    check("conflict_remiss_04", {31'h0, ihit}, 32'h0);
    cycle(1'b1, 32'h4, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    // fills so far: 0x00, 0x04, 0x44, 0x04
    check("conflict_miss_count", miss_count, 32'h4);

    // redirect during the fill of 0x10
    cycle(1'b1, 32'h10, 1'b1);
    cycle(1'b1, 32'h20, 1'b1);
    check("redirect_iaddr", iaddr, 32'h10);
    cycle(1'b1, 32'h20, 1'b0);
    check("redirect_no_ihit", {31'h0, ihit}, 32'h0);
    check("redirect_load_zero", imemload, 32'h0);
    cycle(1'b1, 32'h20, 1'b1);
    check("redirect_idle", {31'h0, state_dbg}, 32'h0);
    cycle(1'b1, 32'h20, 1'b1);
    check("redirect_new_fill", iaddr, 32'h20);
    cycle(1'b1, 32'h20, 1'b0);
    cycle(1'b1, 32'h10, 1'b1);
    check("redirect_frame4_valid", {31'h0, ihit}, 32'h1);

    // asynchronous reset while a fill is waiting
    cycle(1'b1, 32'h30, 1'b1);
    cycle(1'b1, 32'h30, 1'b1);
    #2;
    imemREN = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_iREN", {31'h0, iREN}, 32'h0);
    check("async_rst_iaddr", iaddr, 32'h0);
    check("async_rst_hits", hit_count, 32'h0);
    check("async_rst_state", {31'h0, state_dbg}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h10, 1'b1);
    check("post_rst_miss", {31'h0, ihit}, 32'h0);
    cycle(1'b1, 32'h10, 1'b0);

    // random fetch streams with redirects, drops of imemREN and random memory stalls
    cur = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        cur = 32'($urandom_range(0, 95)) << 2;
        if ($urandom_range(0, 9) == 0) cur = cur | 32'h8000_0000;
      end
      cycle($urandom_range(0, 9) < 8, cur, $urandom_range(0, 1) == 1);
    end

    // counter saturation: preload hit_count, then hit twice
    while (m_filling) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h10, 1'b1);
    if (m_filling) cycle(1'b1, 32'h10, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    #2;
    force dut.hit_count_q = 32'hFFFF_FFFE;
    m_hits = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.hit_count_q;
    cycle(1'b1, 32'h10, 1'b1);
    check("sat_preload", hit_count, 32'hFFFF_FFFE);
    cycle(1'b1, 32'h10, 1'b1);
    check("sat_first", hit_count, 32'hFFFF_FFFF);
    cycle(1'b0, 32'h0, 1'b1);
    check("sat_hold", hit_count, 32'hFFFF_FFFF);

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
